// File: rtl/cu_fsm.sv
// cu_fsm: multi-cycle control unit for the single-issue RV32I core.
// Steps each instruction through FETCH -> EXEC (-> WRITEBACK for loads),
// inserts an INTRPT entry cycle at instruction boundaries, and drives the
// PC, register-file, data-memory and CSR strobes for the current step.
module cu_fsm (
    input  logic       clk,
    input  logic       RST_N,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNC3,
    input  logic       INTR,
    input  logic       MIE,
    output logic       PC_WRITE,
    output logic       RST,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_MRET   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WRITEBACK,
        ST_INTRPT
    } state_t;

    state_t state_q, state_d;
    logic   intr_meta_q, intr_meta_d;
    logic   intr_sync_q, intr_sync_d;
    logic   int_pend;

    // Two-flop synchronizer for the asynchronous interrupt request.
    always_comb begin
        intr_meta_d = INTR;
        intr_sync_d = intr_meta_q;
    end

    // MIE comes from the CSR block in this clock domain, so it gates the
    // synchronized request directly.
    assign int_pend = intr_sync_q & MIE;

    // State and synchronizer registers; reset forces INIT without a clock.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_INIT;
            intr_meta_q <= 1'b0;
            intr_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            intr_meta_q <= intr_meta_d;
            intr_sync_q <= intr_sync_d;
        end
    end

    // Next-state and output decode; EXEC outputs depend on the opcode.
    always_comb begin
        state_d   = state_q;
        PC_WRITE  = 1'b0;
        RST       = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;

        case (state_q)
            ST_INIT: begin
                RST     = 1'b1;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                state_d   = ST_EXEC;
            end

            ST_EXEC: begin
                // Loads hold the PC until writeback so the instruction is
                // never split by an interrupt; everything else retires here.
                if (OPCODE == OP_LOAD) begin
                    MEM_RDEN2 = 1'b1;
                    state_d   = ST_WRITEBACK;
                end else begin
                    PC_WRITE = 1'b1;
                    state_d  = int_pend ? ST_INTRPT : ST_FETCH;
                    case (OPCODE)
                        OP_STORE:  MEM_WE2 = 1'b1;
                        OP_BRANCH: ;
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG:
                            REG_WRITE = 1'b1;
                        OP_SYSTEM: begin
                            if (FUNC3 == F3_CSRRW) begin
                                REG_WRITE = 1'b1;
                                CSR_WE    = 1'b1;
                            end else if (FUNC3 == F3_MRET) begin
                                MRET_EXEC = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_WRITEBACK: begin
                PC_WRITE  = 1'b1;
                REG_WRITE = 1'b1;
                state_d   = int_pend ? ST_INTRPT : ST_FETCH;
            end

            ST_INTRPT: begin
                // No re-check of int_pend: the CSR block clears MIE on entry.
                PC_WRITE  = 1'b1;
                INT_TAKEN = 1'b1;
                state_d   = ST_FETCH;
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: an instruction-level reference model pushes
// the expected per-cycle output vector; a negedge monitor pops and compares.
module tb_cu_fsm;

    logic       clk = 1'b0;
    logic       RST_N;
    logic [6:0] OPCODE;
    logic [2:0] FUNC3;
    logic       INTR;
    logic       MIE;
    logic       PC_WRITE, RST, REG_WRITE, MEM_RDEN1, MEM_RDEN2;
    logic       MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC;

    cu_fsm dut (
        .clk       (clk),
        .RST_N     (RST_N),
        .OPCODE    (OPCODE),
        .FUNC3     (FUNC3),
        .INTR      (INTR),
        .MIE       (MIE),
        .PC_WRITE  (PC_WRITE),
        .RST       (RST),
        .REG_WRITE (REG_WRITE),
        .MEM_RDEN1 (MEM_RDEN1),
        .MEM_RDEN2 (MEM_RDEN2),
        .MEM_WE2   (MEM_WE2),
        .CSR_WE    (CSR_WE),
        .INT_TAKEN (INT_TAKEN),
        .MRET_EXEC (MRET_EXEC)
    );

    always #5 clk = ~clk;

    // Output vector bit order: PCW RST REGW RDEN1 RDEN2 WE2 CSRWE INT MRET
    localparam logic [8:0] V_NONE  = 9'b000000000;
    localparam logic [8:0] V_PCW   = 9'b100000000;
    localparam logic [8:0] V_RST   = 9'b010000000;
    localparam logic [8:0] V_REGW  = 9'b001000000;
    localparam logic [8:0] V_RDEN1 = 9'b000100000;
    localparam logic [8:0] V_RDEN2 = 9'b000010000;
    localparam logic [8:0] V_WE2   = 9'b000001000;
    localparam logic [8:0] V_CSRWE = 9'b000000100;
    localparam logic [8:0] V_INT   = 9'b000000010;
    localparam logic [8:0] V_MRET  = 9'b000000001;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic [6:0] op_table [12] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                                  7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011,
                                  7'b0110011, 7'b1110011, 7'b1111111, 7'b0000000};

    wire [8:0] dut_vec = {PC_WRITE, RST, REG_WRITE, MEM_RDEN1, MEM_RDEN2,
                          MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC};

    logic [8:0] exp_q [$];
    bit         intr_hist [$];
    int         checks   = 0;
    int         failures = 0;
    int         mon_cyc  = 0;
    int         intr_mode = 0;   // 0: low, 1: high, 2: random per cycle
    int         mie_mode  = 0;

    task automatic check(input logic [8:0] act, input logic [8:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    function automatic bit pick(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    // Architectural meaning of the EXEC step for each instruction class.
    function automatic logic [8:0] exec_vec(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            LOAD:   return V_RDEN2;
            STORE:  return V_PCW | V_WE2;
            BRANCH: return V_PCW;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, OPIMM, OPR:
                    return V_PCW | V_REGW;
            SYSTEM: begin
                if (f3 == 3'b001) return V_PCW | V_REGW | V_CSRWE;
                if (f3 == 3'b000) return V_PCW | V_MRET;
                return V_PCW;
            end
            default: return V_PCW;
        endcase
    endfunction

    // One clock of stimulus: drive INTR/MIE, predict int_pend for this cycle
    // (INTR from two cycles ago, MIE now), queue the expected outputs.
    task automatic do_cycle(input logic [8:0] vec, input bit in_reset, output bit pend);
        INTR = in_reset ? 1'b0 : pick(intr_mode);
        MIE  = pick(mie_mode);
        intr_hist.push_back(INTR);
        pend = (intr_hist.size() >= 3) ? (intr_hist[intr_hist.size() - 3] & MIE) : 1'b0;
        exp_q.push_back(vec);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3);
        bit p;
        OPCODE = op;
        FUNC3  = f3;
        do_cycle(V_RDEN1, 1'b0, p);
        do_cycle(exec_vec(op, f3), 1'b0, p);
        if (op == LOAD) do_cycle(V_PCW | V_REGW, 1'b0, p);
        if (p) do_cycle(V_PCW | V_INT, 1'b0, p);
    endtask

    task automatic do_reset(input int n);
        bit p;
        RST_N = 1'b0;
        repeat (n) do_cycle(V_RST, 1'b1, p);
        RST_N = 1'b1;
        do_cycle(V_RST, 1'b1, p);
    endtask

    // Monitor: compare every clocked output vector against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_cyc++;
            check(dut_vec, exp_q.pop_front(), $sformatf("outputs_cyc%0d", mon_cyc));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit p;
        RST_N  = 1'b0;
        OPCODE = 7'd0;
        FUNC3  = 3'd0;
        INTR   = 1'b0;
        MIE    = 1'b0;
        @(posedge clk);
        #1;

        do_reset(3);

        // Basic non-load sequence with interrupts masked.
        intr_mode = 2; mie_mode = 0;
        run_instr(OPR, 3'd0);
        run_instr(STORE, 3'd2);
        run_instr(BRANCH, 3'd1);

        // Load, then a load with INTR rising in its FETCH.
        intr_mode = 0; mie_mode = 1;
        run_instr(LOAD, 3'd2);
        run_instr(OPR, 3'd0);
        intr_mode = 1;
        run_instr(LOAD, 3'd2);
        intr_mode = 0; mie_mode = 0;
        run_instr(OPR, 3'd0);
        run_instr(OPR, 3'd0);

        // INTR held high while masked, then enabled before an OP-IMM.
        intr_mode = 1; mie_mode = 0;
        for (int i = 0; i < 10; i++)
            run_instr(op_table[$urandom_range(0, 11)], 3'($urandom_range(0, 7)));
        mie_mode = 1;
        run_instr(OPIMM, 3'd0);
        intr_mode = 0; mie_mode = 0;
        run_instr(OPR, 3'd0);

        // CSR and mret, illegal opcode, then mret colliding with int_pend.
        run_instr(SYSTEM, 3'b001);
        run_instr(SYSTEM, 3'b000);
        run_instr(7'b1111111, 3'd0);
        intr_mode = 1;
        run_instr(OPR, 3'd0);
        mie_mode = 1;
        run_instr(SYSTEM, 3'b000);
        intr_mode = 0; mie_mode = 0;
        run_instr(OPR, 3'd0);

        // Random mix with random interrupt traffic.
        intr_mode = 2; mie_mode = 2;
        for (int i = 0; i < 200; i++)
            run_instr(op_table[$urandom_range(0, 11)], 3'($urandom_range(0, 7)));
        intr_mode = 0; mie_mode = 0;
        run_instr(OPR, 3'd0);
        run_instr(OPR, 3'd0);

        // Asynchronous reset in the EXEC cycle of a store.
        OPCODE = STORE;
        FUNC3  = 3'd0;
        do_cycle(V_RDEN1, 1'b0, p);
        INTR = 1'b0;
        MIE  = 1'b0;
        intr_hist.push_back(1'b0);
        #1 check(dut_vec, V_PCW | V_WE2, "store_exec_before_reset");
        RST_N = 1'b0;
        #1 check(dut_vec, V_RST, "async_reset_in_exec");
        exp_q.push_back(V_RST);
        @(posedge clk);
        #1;
        do_reset(3);
        run_instr(OPIMM, 3'd0);
        run_instr(LOAD, 3'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
